gol_frame_receiver: RTL
=======================

# gol_frame_receiver

Serial-to-parallel receiver for the Game of Life core's status/data output pins. It watches the 2-bit phase code and the serial cell bit, and captures each OUTPUT phase into a 64-cell frame. It presents the frame to a downstream consumer (display driver or host readout) over a valid/ready handshake. It sits on the consumer side of `uo_out[2:0]` and runs on the same clock as the core.

## Interface
- `N_CELLS`, default 64: cells per frame (board is `ROW_W` x `ROW_W`, row-major).
- `ROW_W`, default 8: board edge length.
- `GEN_W`, default 16: generation counter width.
- Clocking and reset (already decided): one clock; reset is asynchronous and active-low (`clk`, `rst_n`).
- `clk`  in  1  clock, same domain as the core.
- `rst_n`  in  1  asynchronous active-low reset.
- `gol_state`  in  2  phase code from the core: 00 INPUT, 01 UPDATE, 10 OUTPUT; 11 is illegal.
- `gol_bit`  in  1  serial cell bit. Meaningful only while `gol_state` is 10.
- `frame_ready`  in  1  consumer accepts the frame.
- `clr_flags`  in  1  one-cycle pulse that clears the sticky flags.
- `frame_valid`  out  1  `frame_data` holds an unconsumed frame.
- `frame_data`  out  N_CELLS  captured frame; bit k is cell k.
- `gen_count`  out  GEN_W  number of complete frames captured.
- `short_err`  out  1  sticky; an OUTPUT phase ended before N_CELLS bits were captured.
- `overrun`  out  1  sticky; a complete frame was dropped because the output register was still full.
- `live_count`  out  $clog2(N_CELLS)+1  population of `frame_data`. Present only under the macro.

## Operation
- Inputs are synchronous to `clk`. No synchronizers.
- FSM states:
  - IDLE:
    - `gol_state`==10 and the previous sampled `gol_state`!=10 (phase entry) → CAPTURE. `gol_bit` is sampled in this same cycle as bit 0 and the bit counter is set to 1.
  - CAPTURE:
    - Samples `gol_bit` every cycle; the shift register shifts right with the new bit entering the MSB.
    - On the cycle the counter reaches N_CELLS (the N_CELLS-th bit is sampled) → DONE.
    - `gol_state` leaves 10 before that → set `short_err`, discard the partial frame → IDLE.
  - DONE (one cycle):
    - Output register free (`!frame_valid`, or `frame_valid && frame_ready` this cycle): load `frame_data` from the shift register, set `frame_valid`, increment `gen_count`.
    - Otherwise: set `overrun`, keep the old frame, still increment `gen_count`.
    - Then → DISCARD if `gol_state`==10, else IDLE.
  - DISCARD:
    - Ignores extra OUTPUT-phase bits (the core holds OUTPUT roughly N_CELLS+1 cycles).
    - `gol_state`!=10 → IDLE.
- `gol_state`==11 in any state: treated as not-OUTPUT.
- `gen_count` wraps from all-ones to 0 silently.
- `clr_flags` clears `short_err` and `overrun`. If a set event occurs in the same cycle, the set wins.
- Bit counter width: $clog2(N_CELLS)+1. It never wraps.

## Timing
- Reset values: all outputs 0; FSM in IDLE; previous-state register = 00.
- Reset asserted mid-capture discards the partial frame. After release, capture needs a fresh OUTPUT entry edge; a phase already in progress is ignored.
- Latency: `frame_valid` rises the clock edge after DONE. That is 2 cycles after the N_CELLS-th bit is sampled.
- Handshake:
  - A transfer occurs on a rising edge with `frame_valid && frame_ready`.
  - After a transfer, `frame_valid` falls on the next edge, unless DONE loads a new frame on that same edge; then it stays high with the new data.
  - `frame_data` is stable whenever `frame_valid` is high and no transfer occurs.
- `frame_ready` while `!frame_valid` has no effect.
- Minimum spacing between complete frames is N_CELLS+2 cycles (UPDATE is 1 cycle). The block sustains back-to-back generations at full rate while the consumer keeps up.

## Configuration
- `GOL_RX_POPCOUNT_EN` defined:
  - A `live_count` port and register are present.
  - The register is updated in the same edge that loads `frame_data`, so it is always consistent with `frame_data`.
  - Reset value 0.
- `GOL_RX_POPCOUNT_EN` undefined: no port and no logic. All other behaviour is identical.

## Structure
- Shared package `gol_pkg`:
  - Phase enum `gol_phase_t` (GOL_INPUT=2'b00, GOL_UPDATE=2'b01, GOL_OUTPUT=2'b10).
  - Constants `GOL_N_CELLS`=64 and `GOL_ROW_W`=8.
  - Both the core and this receiver import it.
- Receiver FSM state enum is local to this block.
- One sub-module: `gol_popcount` (combinational N_CELLS-input population count), instantiated only under `GOL_RX_POPCOUNT_EN`.

## Test plan
- Full frame: reset; drive 00 for 3 cycles, 01 for 1, then 10 for 65 cycles with `gol_bit` = 1 on cycles 0, 9, 63 of the phase; `frame_ready`=1.
  - `frame_data` = 64'h8000_0000_0000_0201.
  - `frame_valid` is high exactly one cycle, 2 cycles after phase bit 63.
  - `gen_count`=1; `live_count`=3 (macro on).
- Short phase: OUTPUT held 40 cycles, then 00 → `short_err`=1, `frame_valid` stays 0, `gen_count`=0. A `clr_flags` pulse → `short_err`=0.
- Overrun: `frame_ready`=0; run two full generations (patterns all-ones then all-zeros).
  - `frame_data` stays all-ones, `overrun`=1, `gen_count`=2.
  - Raising `frame_ready` → one transfer, then `frame_valid`=0.
- Simultaneous accept and load: release `frame_ready` exactly on the DONE cycle of the second frame → `frame_valid` stays high and `frame_data` switches to the second frame with no gap.
- Reset mid-capture: assert `rst_n`=0 at OUTPUT bit 20, release at bit 30 while still in OUTPUT.
  - No capture of the remainder, all outputs 0.
  - The next full OUTPUT phase is captured correctly.
- Wrap and illegal code: preload with 2^GEN_W−1 complete frames (GEN_W=4 build) → `gen_count`=15, then the next frame gives 0. `gol_state`=11 mid-capture → `short_err`=1.

Source files
------------

// File: rtl/gol_pkg.sv
// gol_pkg: phase codes and board constants shared by the Game of Life core and its receiver
package gol_pkg;
  typedef enum logic [1:0] {
    GOL_INPUT  = 2'b00,
    GOL_UPDATE = 2'b01,
    GOL_OUTPUT = 2'b10
  } gol_phase_t;
  localparam int GOL_N_CELLS = 64;
  localparam int GOL_ROW_W   = 8;
endpackage

// File: rtl/gol_popcount.sv
// gol_popcount: combinational population count of an N-bit vector
module gol_popcount #(
  parameter  int N = 64,
  localparam int W = $clog2(N) + 1
) (
  input  logic [N-1:0] bits,
  output logic [W-1:0] count
);
  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) count = count + W'(bits[i]);
  end
endmodule

// File: rtl/gol_frame_receiver.sv
// gol_frame_receiver: deserialises OUTPUT phases into frames with valid/ready; GOL_RX_POPCOUNT_EN adds live_count
module gol_frame_receiver
  import gol_pkg::*;
#(
  parameter  int ROW_W   = GOL_ROW_W,
  parameter  int N_CELLS = ROW_W * ROW_W,
  parameter  int GEN_W   = 16,
  localparam int CW      = $clog2(N_CELLS) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         gol_state,
  input  logic               gol_bit,
  input  logic               frame_ready,
  input  logic               clr_flags,
  output logic               frame_valid,
  output logic [N_CELLS-1:0] frame_data,
  output logic [GEN_W-1:0]   gen_count,
  output logic               short_err,
  output logic               overrun
`ifdef GOL_RX_POPCOUNT_EN
  ,
  output logic [CW-1:0]      live_count
`endif
);
  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DONE, S_DISCARD} rx_state_t;
  rx_state_t state_q, state_d;
  logic [1:0] prev_q;
  logic seen_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N_CELLS-1:0] sr_q, sr_d, data_q, data_d, shifted;
  logic valid_q, valid_d, short_q, short_d, over_q, over_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic is_out, entry, free, load;
  assign is_out  = gol_state == GOL_OUTPUT;
  // seen_q blocks a phase already running when reset releases from looking like an entry
  assign entry   = is_out && prev_q != GOL_OUTPUT && seen_q;
  assign shifted = {gol_bit, sr_q[N_CELLS-1:1]};
  assign free    = !valid_q || frame_ready;
  assign load    = state_q == S_DONE && free;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    case (state_q)
      S_IDLE: if (entry) begin
        state_d = S_CAPTURE;
        cnt_d   = CW'(1);
        sr_d    = shifted;
      end
      S_CAPTURE: if (!is_out) state_d = S_IDLE;
      else begin
        sr_d    = shifted;
        cnt_d   = cnt_q + CW'(1);
        state_d = cnt_d == CW'(N_CELLS) ? S_DONE : S_CAPTURE;
      end
      default: state_d = is_out ? S_DISCARD : S_IDLE;
    endcase
    data_d  = load ? sr_q : data_q;
    valid_d = load || (valid_q && !frame_ready);
    gen_d   = state_q == S_DONE ? gen_q + GEN_W'(1) : gen_q;
    short_d = (state_q == S_CAPTURE && !is_out) || (short_q && !clr_flags);
    over_d  = (state_q == S_DONE && !free) || (over_q && !clr_flags);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      prev_q  <= GOL_INPUT;
      seen_q  <= 1'b0;
      cnt_q   <= '0;
      sr_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      gen_q   <= '0;
      short_q <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= gol_state;
      seen_q  <= 1'b1;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      gen_q   <= gen_d;
      short_q <= short_d;
      over_q  <= over_d;
    end
  end
  assign frame_valid = valid_q;
  assign frame_data  = data_q;
  assign gen_count   = gen_q;
  assign short_err   = short_q;
  assign overrun     = over_q;
`ifdef GOL_RX_POPCOUNT_EN
  logic [CW-1:0] pop, live_q, live_d;
  gol_popcount #(.N(N_CELLS)) u_popcount (.bits(sr_q), .count(pop));
  assign live_d = load ? pop : live_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) live_q <= '0;
    else live_q <= live_d;
  end
  assign live_count = live_q;
`endif
endmodule
